// File: rtl/dac_i2s_tx.sv
// dac_i2s_tx: frame FIFO, optional volume scaling (macro DAC_I2S_VOLUME_EN) and I2S serializer.
// Ports: clk_i/rst_i (async active-low) clock and reset; samp_wr_req_i/lr_chan_data_i frame write;
// volume_i level 0..127; clear_i FIFO flush; dac_fifo_almfull_o/fifo_usedw_o fill status;
// overflow_o/underrun_o event pulses; i2s_bclk_o/i2s_lrclk_o/i2s_data_o I2S bus.
module dac_i2s_tx #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 64,
  parameter int ALMFULL_LVL  = 56,
  parameter int BCLK_DIV     = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          samp_wr_req_i,
  input  logic [2*SAMPLE_WIDTH-1:0]     lr_chan_data_i,
  input  logic [6:0]                    volume_i,
  input  logic                          clear_i,
  output logic                          dac_fifo_almfull_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_usedw_o,
  output logic                          overflow_o,
  output logic                          underrun_o,
  output logic                          i2s_bclk_o,
  output logic                          i2s_lrclk_o,
  output logic                          i2s_data_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * SAMPLE_WIDTH;
  localparam int BW = $clog2(FW);
  localparam int DW = $clog2(BCLK_DIV);
  logic [FW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt, bit_nxt;
  logic          run;
  logic [FW-1:0] sr, head, frame;
  logic          tc, fall, load, full, empty, wr_ok, pop;
  assign tc      = div_cnt == DW'(BCLK_DIV - 1);
  assign fall    = tc & i2s_bclk_o;
  // the very first falling edge after reset is treated as a wrap so it loads a frame
  assign bit_nxt = (!run || bit_cnt == BW'(FW - 1)) ? '0 : bit_cnt + BW'(1);
  assign load    = fall & (bit_nxt == '0);
  assign full    = fifo_usedw_o == (AW+1)'(FIFO_DEPTH);
  assign empty   = fifo_usedw_o == '0;
  assign wr_ok   = samp_wr_req_i & ~full & ~clear_i;
  assign pop     = load & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];
  assign dac_fifo_almfull_o = fifo_usedw_o >= (AW+1)'(ALMFULL_LVL);
  assign i2s_data_o = sr[FW-1];
`ifdef DAC_I2S_VOLUME_EN
  function automatic logic [SAMPLE_WIDTH-1:0] scale(input logic [SAMPLE_WIDTH-1:0] s, input logic [6:0] v);
    logic signed [SAMPLE_WIDTH+7:0] p;
    p = (SAMPLE_WIDTH+8)'($signed(s)) * (SAMPLE_WIDTH+8)'($signed({1'b0, v}));
    return SAMPLE_WIDTH'(p >>> 7);
  endfunction
  assign frame = {scale(head[FW-1:SAMPLE_WIDTH], volume_i), scale(head[SAMPLE_WIDTH-1:0], volume_i)};
`else
  logic unused_vol;
  assign unused_vol = ^volume_i;
  assign frame = head;
`endif
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= lr_chan_data_i;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      run          <= 1'b0;
      sr           <= '0;
      i2s_bclk_o   <= 1'b0;
      i2s_lrclk_o  <= 1'b0;
      underrun_o   <= 1'b0;
      overflow_o   <= 1'b0;
      fifo_usedw_o <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
    end else begin
      div_cnt <= tc ? '0 : div_cnt + DW'(1);
      if (tc) i2s_bclk_o <= ~i2s_bclk_o;
      if (fall) begin
        bit_cnt <= bit_nxt;
        run     <= 1'b1;
        sr      <= load ? frame : sr << 1;
        // word select leads the data by one bit
        if (bit_nxt == BW'(SAMPLE_WIDTH - 1)) i2s_lrclk_o <= 1'b1;
        else if (bit_nxt == BW'(FW - 1)) i2s_lrclk_o <= 1'b0;
      end
      underrun_o <= load & empty;
      overflow_o <= samp_wr_req_i & full & ~clear_i;
      if (clear_i) begin
        fifo_usedw_o <= '0;
        rd_ptr       <= wr_ptr;
      end else begin
        fifo_usedw_o <= fifo_usedw_o + (AW+1)'(wr_ok) - (AW+1)'(pop);
        if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
        if (pop) rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end
endmodule

// File: tb/tb_dac_i2s_tx.sv
// tb_dac_i2s_tx: randomized scoreboard bench for dac_i2s_tx against a queue-based reference model.
module tb_dac_i2s_tx;
  logic        clk = 0, rst_i = 0, samp_wr_req_i = 0, clear_i = 0;
  logic [31:0] lr_chan_data_i = 0;
  logic [6:0]  volume_i = 0;
  logic        dac_fifo_almfull_o, overflow_o, underrun_o, i2s_bclk_o, i2s_lrclk_o, i2s_data_o;
  logic [6:0]  fifo_usedw_o;
  int n_chk = 0, n_fail = 0, e = 0;
  logic [31:0] mq[$];
  logic [31:0] exp_q[$];
  logic exp_u = 0, exp_o = 0;
  localparam int END = 256 * 12 + 8 + 254;

  dac_i2s_tx dut (
    .clk_i(clk), .rst_i(rst_i), .samp_wr_req_i(samp_wr_req_i), .lr_chan_data_i(lr_chan_data_i),
    .volume_i(volume_i), .clear_i(clear_i), .dac_fifo_almfull_o(dac_fifo_almfull_o),
    .fifo_usedw_o(fifo_usedw_o), .overflow_o(overflow_o), .underrun_o(underrun_o),
    .i2s_bclk_o(i2s_bclk_o), .i2s_lrclk_o(i2s_lrclk_o), .i2s_data_o(i2s_data_o));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, e, act, want);
    end
  endtask

  function automatic logic [15:0] scale_ref(input logic [15:0] f, input int v);
`ifdef DAC_I2S_VOLUME_EN
    logic signed [15:0] x;
    int p, q;
    x = f;
    p = int'(x) * v;
    q = p / 128;
    if (p < 0 && p % 128 != 0) q--;
    return q[15:0];
`else
    return f;
`endif
  endfunction

  // one clock edge of the reference: frame loads every 256 edges from edge 8
  task automatic model_step(input logic wr, input logic [31:0] d, input logic clr, input int v);
    logic [31:0] f;
    logic was_full;
    was_full = mq.size() == 64;
    exp_u = 0;
    exp_o = 0;
    if (e % 256 == 8) begin
      if (mq.size() == 0) begin
        exp_q.push_back(32'h0);
        exp_u = 1;
      end else begin
        f = mq.pop_front();
        exp_q.push_back({scale_ref(f[31:16], v), scale_ref(f[15:0], v)});
      end
    end
    if (clr) mq.delete();
    else if (wr) begin
      if (was_full) exp_o = 1;
      else mq.push_back(d);
    end
  endtask

  // monitor: deserialize the I2S stream; a frame ends on the bit where word select returns to left
  initial begin
    logic [31:0] sh = 0;
    logic prev_lr = 0;
    forever begin
      @(posedge i2s_bclk_o);
      #1;
      sh = {sh[30:0], i2s_data_o};
      if (prev_lr && !i2s_lrclk_o) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL frame: got %h with no frame expected", sh);
        end else chk("frame", sh, exp_q.pop_front());
      end
      prev_lr = i2s_lrclk_o;
    end
  end

  // word select toggles only on 128-edge boundaries
  initial begin
    logic prev = 0;
    forever begin
      @(negedge clk);
      if (rst_i && i2s_lrclk_o !== prev) chk("lrclk_edge_pos", e % 128, 0);
      prev = i2s_lrclk_o;
    end
  end

  initial begin
    int n;
    logic wr, clr;
    logic [31:0] d;
    int v;
    repeat (3) @(negedge clk);
    chk("rst_usedw", 32'(fifo_usedw_o), 0);
    chk("rst_almfull", 32'(dac_fifo_almfull_o), 0);
    chk("rst_overflow", 32'(overflow_o), 0);
    chk("rst_underrun", 32'(underrun_o), 0);
    chk("rst_bclk", 32'(i2s_bclk_o), 0);
    chk("rst_lrclk", 32'(i2s_lrclk_o), 0);
    chk("rst_data", 32'(i2s_data_o), 0);
    rst_i = 1;
    while (e < END) begin
      n = e + 1;
      wr = 0;
      clr = 0;
      d = $urandom;
      if (n == 300) begin wr = 1; d = {16'h4000, 16'hC000}; end
      if (n == 301) begin wr = 1; d = {16'h8000, 16'h8000}; end
      if (n == 302) begin wr = 1; d = {16'h1234, 16'h1234}; end
      if (n >= 1100 && n < 1170) wr = 1;
      if (n == 1400 || n == 1430) begin wr = 1; clr = 1; end
      if (n >= 1410 && n < 1420) wr = 1;
      if (n >= 1600 && n < 1605) wr = 1;
      if (n >= 1605 && $urandom_range(0, 149) == 0) wr = 1;
      v = n < 700 ? 64 : n < 900 ? 127 : n < 1100 ? 0 : int'($urandom_range(0, 127));
      samp_wr_req_i = wr;
      lr_chan_data_i = d;
      clear_i = clr;
      volume_i = 7'(v);
      @(posedge clk);
      e++;
      model_step(wr, d, clr, v);
      @(negedge clk);
      chk("usedw", 32'(fifo_usedw_o), 32'(mq.size()));
      chk("almfull", 32'(dac_fifo_almfull_o), 32'(mq.size() >= 56));
      chk("underrun", 32'(underrun_o), 32'(exp_u));
      chk("overflow", 32'(overflow_o), 32'(exp_o));
    end
    samp_wr_req_i = 0;
    clear_i = 0;
    chk("frames_left", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
